// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcode classes, ALU control groups,
// operand-A select encodings and the decoded control bundle layout.
package riscv_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LUI    = 7'b0110111;

  localparam logic [2:0] ALU_GRP_BASE = 3'b000;
  localparam logic [2:0] ALU_GRP_ALT  = 3'b001;
  localparam logic [2:0] ALU_GRP_BR   = 3'b010;
  localparam logic [2:0] ALU_GRP_JAL  = 3'b011;
  localparam logic [2:0] ALU_GRP_MUL  = 3'b100;
  localparam logic [2:0] ALU_GRP_JALR = 3'b111;

  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b01;
  localparam logic [1:0] OPA_LINK = 2'b10;

  localparam int REG_SEL_W  = 5;
  localparam int IMM_W      = 32;
  localparam int OPA_SEL_W  = 2;
  localparam int ALU_CTRL_W = 6;

  typedef struct packed {
    logic [REG_SEL_W-1:0]  read_sel1;
    logic [REG_SEL_W-1:0]  read_sel2;
    logic [REG_SEL_W-1:0]  write_sel;
    logic                  wen;
    logic                  mem_wen;
    logic                  branch_op;
    logic                  wb_sel;
    logic [IMM_W-1:0]      imm32;
    logic [OPA_SEL_W-1:0]  op_a_sel;
    logic                  op_b_sel;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  illegal;
  } dec_bundle_t;

  localparam int BUNDLE_W = $bits(dec_bundle_t);

endpackage

// File: rtl/rv_decode_comb.sv
// Pure combinational RV32I(+M) decoder: raw instruction -> control bundle,
// plus the J-immediate used for local JAL target resolution.
module rv_decode_comb import riscv_pkg::*; #(
  parameter int ENABLE_M = 0
) (
  input  logic [31:0]         instruction,
  output logic [BUNDLE_W-1:0] bundle,
  output logic                is_jal,
  output logic [31:0]         imm_j
);

  dec_bundle_t b;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u;
  logic        m_op;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};

  assign is_jal = (opcode == JAL);
  assign m_op   = (ENABLE_M != 0) && (funct7 == 7'b0000001);
  assign bundle = b;

  always_comb begin
    b           = '0;
    b.read_sel1 = instruction[19:15];
    b.read_sel2 = instruction[24:20];
    b.write_sel = instruction[11:7];
    case (opcode)
      R_TYPE: begin
        b.wen      = 1'b1;
        b.op_b_sel = 1'b1;
        b.alu_ctrl = m_op ? {ALU_GRP_MUL, funct3}
                          : {funct7[5] ? ALU_GRP_ALT : ALU_GRP_BASE, funct3};
        b.illegal  = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000) || m_op);
      end
      I_TYPE: begin
        // bit 30 only distinguishes SRAI from SRLI; elsewhere it is immediate data
        b.wen      = 1'b1;
        b.imm32    = imm_i;
        b.alu_ctrl = {(funct3 == 3'b101 && funct7[5]) ? ALU_GRP_ALT : ALU_GRP_BASE, funct3};
      end
      STORE: begin
        b.mem_wen  = 1'b1;
        b.imm32    = imm_s;
        b.alu_ctrl = {ALU_GRP_BASE, funct3};
        b.illegal  = (funct3 > 3'b010);
      end
      LOAD: begin
        b.wen      = 1'b1;
        b.wb_sel   = 1'b1;
        b.imm32    = imm_i;
        b.alu_ctrl = {ALU_GRP_BASE, funct3};
        b.illegal  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      BRANCH: begin
        b.branch_op = 1'b1;
        b.op_b_sel  = 1'b1;
        b.imm32     = imm_b;
        b.alu_ctrl  = {ALU_GRP_BR, funct3};
        b.illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      JALR: begin
        b.wen      = 1'b1;
        b.op_a_sel = OPA_LINK;
        b.imm32    = imm_i;
        b.alu_ctrl = {ALU_GRP_JALR, 3'b111};
      end
      JAL: begin
        b.wen      = 1'b1;
        b.op_a_sel = OPA_LINK;
        b.imm32    = imm_j;
        b.alu_ctrl = {ALU_GRP_JAL, 3'b111};
      end
      AUIPC: begin
        b.wen      = 1'b1;
        b.op_a_sel = OPA_PC;
        b.imm32    = imm_u;
      end
      LUI: begin
        // rs1 is forced to x0 so the rs1+imm datapath yields the bare immediate
        b.wen       = 1'b1;
        b.read_sel1 = '0;
        b.imm32     = imm_u;
      end
      default: begin
        b         = '0;
        b.illegal = 1'b1;
      end
    endcase
    if (b.write_sel == '0 || b.illegal) b.wen = 1'b0;
    if (b.illegal) b.mem_wen = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: one-entry valid/ready pipeline register around
// rv_decode_comb, with execute flush and local JAL redirect of fetch.
module decode_stage import riscv_pkg::*; #(
  parameter int                      ADDRESS_BITS = 16,
  parameter int                      ENABLE_M     = 0,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC_TAG = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    f_valid,
  output logic                    f_ready,
  input  logic [ADDRESS_BITS-1:0] f_PC,
  input  logic [31:0]             f_instruction,
  input  logic                    flush,
  output logic                    jal_redirect,
  output logic [ADDRESS_BITS-1:0] jal_target,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [ADDRESS_BITS-1:0] d_PC,
  output logic [4:0]              d_read_sel1,
  output logic [4:0]              d_read_sel2,
  output logic [4:0]              d_write_sel,
  output logic                    d_wEn,
  output logic                    d_mem_wEn,
  output logic                    d_branch_op,
  output logic                    d_wb_sel,
  output logic [31:0]             d_imm32,
  output logic [1:0]              d_op_A_sel,
  output logic                    d_op_B_sel,
  output logic [5:0]              d_ALU_Control,
  output logic                    d_illegal
);

  logic [BUNDLE_W-1:0]     dec_raw;
  dec_bundle_t             dec, bundle_d, bundle_q;
  logic                    is_jal;
  logic [31:0]             imm_j;
  logic                    accept;
  logic                    valid_d, valid_q;
  logic                    redirect_d, redirect_q;
  logic [ADDRESS_BITS-1:0] pc_d, pc_q;

  rv_decode_comb #(.ENABLE_M(ENABLE_M)) u_dec (
    .instruction (f_instruction),
    .bundle      (dec_raw),
    .is_jal      (is_jal),
    .imm_j       (imm_j)
  );

  assign dec        = dec_bundle_t'(dec_raw);
  assign f_ready    = (~valid_q | d_ready) & ~flush;
  assign accept     = f_valid & f_ready;
  assign jal_target = ADDRESS_BITS'(32'(f_PC) + imm_j);

  // flush outranks accept, hold and redirect; accept outranks drain
  always_comb begin
    valid_d    = valid_q;
    bundle_d   = bundle_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d    = 1'b1;
      bundle_d   = dec;
      pc_d       = f_PC;
      redirect_d = is_jal;
    end else if (d_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
      pc_q       <= RESET_PC_TAG;
      bundle_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      redirect_q <= redirect_d;
      pc_q       <= pc_d;
      bundle_q   <= bundle_d;
    end
  end

  assign d_valid       = valid_q;
  assign jal_redirect  = redirect_q;
  assign d_PC          = pc_q;
  assign d_read_sel1   = bundle_q.read_sel1;
  assign d_read_sel2   = bundle_q.read_sel2;
  assign d_write_sel   = bundle_q.write_sel;
  assign d_wEn         = bundle_q.wen;
  assign d_mem_wEn     = bundle_q.mem_wen;
  assign d_branch_op   = bundle_q.branch_op;
  assign d_wb_sel      = bundle_q.wb_sel;
  assign d_imm32       = bundle_q.imm32;
  assign d_op_A_sel    = bundle_q.op_a_sel;
  assign d_op_B_sel    = bundle_q.op_b_sel;
  assign d_ALU_Control = bundle_q.alu_ctrl;
  assign d_illegal     = bundle_q.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined successor to the combinational RV32I decoder: a registered decode stage between fetch and execute.
- Decodes one instruction per cycle into a control bundle and holds it in a one-entry pipeline register with valid/ready handshakes on both sides.
- Resolves JAL targets locally and redirects fetch. Supports flush from execute.
- Optional M-extension decode and illegal-instruction detection.

Parameters:
- ADDRESS_BITS, 16, PC and target width (4..32).
- ENABLE_M, 0, 1 = decode RV32M (funct7=0000001 under R_TYPE) as legal.
- RESET_PC_TAG, 0, value loaded into d_PC on reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- f_valid  in  1  fetch presents an instruction.
- f_ready  out  1  stage accepts this cycle.
- f_PC  in  ADDRESS_BITS  PC of presented instruction.
- f_instruction  in  32  raw instruction.
- flush  in  1  execute mispredict/JALR redirect; kill the held and incoming instruction.
- jal_redirect  out  1  one-cycle pulse: fetch must load jal_target.
- jal_target  out  ADDRESS_BITS  PC + J-immediate, truncated.
- d_valid  out  1  register holds a valid decoded instruction.
- d_ready  in  1  execute accepts.
- d_PC  out  ADDRESS_BITS  PC of held instruction.
- d_read_sel1, d_read_sel2, d_write_sel  out  5 each  register selects.
- d_wEn, d_mem_wEn, d_branch_op, d_wb_sel  out  1 each  as in the single-cycle core.
- d_imm32  out  32  selected immediate.
- d_op_A_sel  out  2  00 rs1, 01 PC, 10 PC (link).
- d_op_B_sel  out  1  1 = rs2, 0 = imm.
- d_ALU_Control  out  6  ALU operation code.
- d_illegal  out  1  held instruction unrecognised.

Behaviour:
- Reset (async, immediate): d_valid=0, jal_redirect=0, d_PC=RESET_PC_TAG, all other d_* outputs=0.
- f_ready = ~d_valid | d_ready. Accept = f_valid & f_ready. Combinational; no path from d_ready to d_* outputs.
- On accept, the decoded bundle is registered next edge: latency 1 cycle, throughput 1/cycle.
- If d_valid & ~d_ready, hold all d_* outputs stable.
- If d_ready and no accept, d_valid goes to 0. Bundle contents are don't-care but must not change d_valid semantics.
- Decoding rules (opcode classes R, I, STORE, LOAD, BRANCH, JALR, JAL, AUIPC, LUI):
  - ALU_Control:
    - {000,funct3} for R/I with funct7[5]=0, and for LOAD/STORE.
    - {001,funct3} for R/I with funct7[5]=1.
    - {010,funct3} for BRANCH.
    - 011111 for JAL.
    - 111111 for JALR.
    - 000000 for LUI/AUIPC.
    - {100,funct3} for M ops when ENABLE_M=1.
  - I_TYPE shift funct7[5] rule applies only to funct3=101. For I_TYPE funct3≠101, ALU_Control = {000,funct3} regardless of bit 30.
  - Immediates: I for I_TYPE/LOAD/JALR; S; B; J; U for AUIPC/LUI.
  - wEn is forced 0 when write_sel=0.
- d_illegal=1 for:
  - unknown opcode;
  - R_TYPE funct7 not in {0000000, 0100000, 0000001 when ENABLE_M};
  - LOAD funct3 in {011,110,111};
  - STORE funct3>010;
  - BRANCH funct3 in {010,011}.
- When d_illegal=1: d_wEn=0 and d_mem_wEn=0. d_valid still asserts so execute can trap.
- JAL: jal_target = (f_PC + J-imm) mod 2^ADDRESS_BITS, computed from the fetch-side inputs. jal_redirect pulses high for exactly the cycle after an accepted JAL.
- Flush:
  - Next edge: d_valid=0, jal_redirect=0, no accept that cycle (f_ready forced 0 while flush=1).
  - flush has priority over accept, hold, and JAL redirect.
- Reset mid-operation drops the held instruction; no partial state survives.
- Simultaneous d_ready and accept: the new bundle replaces the old in the same edge (no bubble).

Decomposition:
- Package riscv_pkg:
  - opcode localparams (R_TYPE…LUI);
  - ALU_Control group codes (000/001/010/011/100/111);
  - op_A_sel encodings;
  - decode-bundle field widths.
- Sub-module rv_decode_comb: the pure combinational decoder producing the bundle, illegal flag and J/B/I/S/U immediates. The stage adds the handshake register, flush and JAL redirect.

Test Plan:
- Reset held, then released: d_valid=0, d_PC=RESET_PC_TAG, f_ready=1.
- Accept ADDI x5,x0,-1 (0xFFF00293) at PC 0x0010:
  - next cycle d_valid=1;
  - d_imm32=0xFFFFFFFF, d_ALU_Control=000000, d_wEn=1, d_write_sel=5, d_op_B_sel=0.
- Back-pressure: hold d_ready=0 for 3 cycles after accepting SUB (0x40B50533):
  - d_* stable, d_ALU_Control=001000;
  - f_ready=0 throughout.
- JAL x1,+8 (0x008000EF) at PC 0x0020:
  - jal_target=0x0028 the same cycle;
  - jal_redirect=1 for exactly one cycle;
  - d_ALU_Control=011111, d_op_A_sel=10.
- flush asserted with d_valid=1 and f_valid=1: next cycle d_valid=0, no accept.
- MUL x3,x1,x2 (0x022081B3):
  - ENABLE_M=0 → d_illegal=1, d_wEn=0;
  - ENABLE_M=1 → d_ALU_Control=100000, d_illegal=0.
